// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared types, constants and width helpers for the ADC scan controller
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_EOC = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_MUL      = 3'd3,
        ST_SHIFT    = 3'd4
    } scan_state_t;

    localparam int DRP_ADDR_W = 7;

    // Product of a 16-bit code and the scaling factor never overflows this width.
    function automatic int prod_width(input int scaling_factor);
        return 16 + $clog2(scaling_factor) + 1;
    endfunction

    // Channel index width, at least one bit so a single-channel build still has a tag.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/adc_rr_select.sv
// rtl/adc_rr_select.sv - combinational round-robin finder of the next enabled channel after a pointer
module adc_rr_select
    import adc_scan_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = ch_width(NUM_CH)
) (
    input  logic [CW-1:0]     i_ptr,
    input  logic [NUM_CH-1:0] i_mask,
    output logic [CW-1:0]     o_next,
    output logic              o_any
);

    // Lowest enabled index above the pointer wins; otherwise wrap to the lowest enabled index at or below it.
    always_comb begin
        o_next = '0;
        o_any  = |i_mask;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (i_mask[j] && (CW'(j) <= i_ptr)) begin
                o_next = CW'(j);
            end
        end
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (i_mask[j] && (CW'(j) > i_ptr)) begin
                o_next = CW'(j);
            end
        end
    end

endmodule

// File: rtl/adc_scan_controller.sv
// rtl/adc_scan_controller.sv - round-robin ADC DRP channel scanner with shared scaler; optional ADC_SCAN_TIMEOUT_EN
module adc_scan_controller
    import adc_scan_pkg::*;
#(
    parameter int                    NUM_CH         = 4,
    parameter logic [DRP_ADDR_W-1:0] CH_ADDR_BASE   = 7'h10,
    parameter int                    SCALING_FACTOR = 79993,
    parameter int                    SHIFT_FACTOR   = 19,
    parameter logic [NUM_CH-1:0]     SCALE_MASK     = '1,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        eoc,
    input  logic [NUM_CH-1:0]           ch_enable,
    output logic                        drp_en,
    output logic [DRP_ADDR_W-1:0]       drp_addr,
    input  logic                        drp_rdy,
    input  logic [15:0]                 drp_do,
    output logic [15:0]                 sample_data,
    output logic [ch_width(NUM_CH)-1:0] sample_ch,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        overrun,
    output logic                        timeout_err
);

    localparam int CW = ch_width(NUM_CH);
    localparam int PW = prod_width(SCALING_FACTOR);

    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic                  r_eoc_q;
    logic                  w_eoc_rise;
    logic                  w_accept;
    logic                  w_to_expire;
    logic [CW-1:0]         r_ptr;
    logic [CW-1:0]         w_next_ch;
    logic                  w_any_en;
    logic [DRP_ADDR_W-1:0] r_drp_addr;
    logic [15:0]           r_raw;
    logic [PW-1:0]         r_prod;
    logic                  r_scale;
    logic [15:0]           r_sample_data;
    logic [CW-1:0]         r_sample_ch;
    logic                  r_sample_valid;
    logic                  r_overrun;

    assign w_eoc_rise = eoc & ~r_eoc_q;
    // An edge with no channel enabled is simply ignored and does not leave WAIT_EOC.
    assign w_accept   = (r_state == ST_WAIT_EOC) && w_eoc_rise && w_any_en;

    adc_rr_select #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_rr_select (
        .i_ptr  (r_ptr),
        .i_mask (ch_enable),
        .o_next (w_next_ch),
        .o_any  (w_any_en)
    );

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;

    assign w_to_expire = (r_state == ST_WAIT_RDY) && !drp_rdy &&
                         (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    // Count cycles spent waiting for read data; restart on every entry to WAIT_RDY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != ST_WAIT_RDY) begin
                r_to_cnt <= '0;
            end else if (!drp_rdy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    // Without the timeout the parameter has no hardware; this keeps it referenced.
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_to_expire      = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT_EOC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the scan sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_EOC: begin
                if (w_accept) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_next = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (drp_rdy) begin
                    w_state_next = ST_MUL;
                end else if (w_to_expire) begin
                    w_state_next = ST_WAIT_EOC;
                end
            end
            ST_MUL: begin
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_state_next = ST_WAIT_EOC;
            end
            default: begin
                w_state_next = ST_WAIT_EOC;
            end
        endcase
    end

    // Edge detect, channel pointer and DRP address; the pointer starts at the last channel so channel 0 is picked first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_eoc_q    <= 1'b0;
            r_ptr      <= CW'(NUM_CH - 1);
            r_drp_addr <= '0;
        end else begin
            r_eoc_q <= eoc;
            if (w_accept) begin
                r_ptr      <= w_next_ch;
                r_drp_addr <= CH_ADDR_BASE + DRP_ADDR_W'(w_next_ch);
            end
        end
    end

    // Shared scaler pipeline: capture, multiply (or pass raw), then shift and publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_raw          <= '0;
            r_prod         <= '0;
            r_scale        <= 1'b0;
            r_sample_data  <= '0;
            r_sample_ch    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if ((r_state == ST_WAIT_RDY) && drp_rdy) begin
                r_raw <= drp_do;
            end
            if (r_state == ST_MUL) begin
                r_scale <= SCALE_MASK[r_ptr];
                r_prod  <= SCALE_MASK[r_ptr] ? (PW'(r_raw) * PW'(SCALING_FACTOR)) : PW'(r_raw);
            end
            if (r_state == ST_SHIFT) begin
                r_sample_data  <= r_scale ? 16'(r_prod >> SHIFT_FACTOR) : r_prod[15:0];
                r_sample_ch    <= r_ptr;
                r_sample_valid <= 1'b1;
            end
        end
    end

    // Sticky overrun: any conversion edge that arrives mid-scan is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_eoc_rise && (r_state != ST_WAIT_EOC)) begin
            r_overrun <= 1'b1;
        end
    end

    assign drp_en       = (r_state == ST_REQ);
    assign drp_addr     = r_drp_addr;
    assign busy         = (r_state != ST_WAIT_EOC);
    assign sample_data  = r_sample_data;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;

endmodule
